// File: rtl/lock_pkg.sv
// Shared types for the lock control path: lock FSM states, pulse_to_level
// states, and width helpers for the pulse_to_level counters.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } p2l_state_t;

    typedef enum logic [1:0] {
        LOCK_LOCKED    = 2'd0,
        LOCK_UNLOCKING = 2'd1,
        LOCK_OPEN      = 2'd2,
        LOCK_LOCKING   = 2'd3
    } lock_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Hold/gap counter width; floor of 2 keeps the counter at least one bit wide.
    function automatic int unsigned p2l_cnt_w(input int unsigned hold_ticks,
                                              input int unsigned gap_ticks);
        return $clog2(max3(hold_ticks, gap_ticks, 2));
    endfunction

    function automatic int unsigned p2l_presc_w(input int unsigned div);
        return $clog2((div < 2) ? 2 : div);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler emitting a one-cycle clock-enable every DIV clocks;
// clr restarts the count so the next tick lands exactly DIV cycles later.
module tick_gen
    import lock_pkg::*;
#(
    parameter int unsigned DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     PW   = p2l_presc_w(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clr || (presc_q == LAST)) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = (presc_q == LAST);

endmodule

// File: rtl/pulse_to_level.sv
// Stretches single-cycle strobes into a level held HOLD_TICKS slow ticks,
// followed by GAP_TICKS of busy low time. Define PULSE_TO_LEVEL_RETRIGGER_EN
// to let a strobe during the hold restart it instead of being dropped.
module pulse_to_level
    import lock_pkg::*;
#(
    parameter int unsigned DIV        = 100000000,
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned GAP_TICKS  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level_out,
    output logic busy,
    output logic drop
);

    localparam int unsigned   CW        = p2l_cnt_w(HOLD_TICKS, GAP_TICKS);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

    p2l_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          busy_q;
    logic          drop_q;
    logic          accept;
    logic          tick;

`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
    assign accept = pulse_in && ((state_q == IDLE) || (state_q == HOLD));
`else
    assign accept = pulse_in && (state_q == IDLE);
`endif

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // An accepted strobe outranks a coincident expiry tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= pulse_in && !accept;
            if (accept) begin
                state_q <= HOLD;
                cnt_q   <= HOLD_LOAD;
                level_q <= 1'b1;
                busy_q  <= 1'b1;
            end else if (tick) begin
                case (state_q)
                    HOLD: begin
                        if (cnt_q == '0) begin
                            level_q <= 1'b0;
                            if (GAP_TICKS == 0) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= GAP;
                                cnt_q   <= GAP_LOAD;
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level: expected windows come from the pulse timing
// rules, drop strobes are queued when an ignored pulse is driven.
module tb_pulse_to_level;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pulse_a = 1'b0;
    logic pulse_b = 1'b0;
    logic lvl_a, busy_a, drop_a;
    logic lvl_b, busy_b, drop_b;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int base     = 0;
    bit retrig   = 1'b0;

    int p_div  [2];
    int p_hold [2];
    int p_gap  [2];
    int acc_e  [2];
    int hold_e [2];
    int busy_e [2];

    typedef struct {
        int dut;
        int edge_n;
    } drop_t;
    drop_t drop_q[$];

    always #5 clk = ~clk;

    pulse_to_level #(.DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_a),
        .level_out (lvl_a),
        .busy      (busy_a),
        .drop      (drop_a)
    );

    pulse_to_level #(.DIV(1), .HOLD_TICKS(1), .GAP_TICKS(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_b),
        .level_out (lvl_b),
        .busy      (busy_b),
        .drop      (drop_b)
    );

    task automatic chk(input string tag, input int dut, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s dut%0d edge %0d: observed %b expected %b", tag, dut, edge_cnt, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            acc_e[d]  = -1;
            hold_e[d] = -1;
            busy_e[d] = -1;
        end
        drop_q.delete();
    endtask

    task automatic decide(input int d);
        int    e;
        drop_t ent;
        e = edge_cnt;
        if (e > busy_e[d]) begin
            acc_e[d]  = e;
            hold_e[d] = e + p_hold[d] * p_div[d];
            busy_e[d] = e + (p_hold[d] + p_gap[d]) * p_div[d];
            $display("edge %0d dut%0d pulse accepted, hold until edge %0d", e, d, hold_e[d]);
        end else if (retrig && e <= hold_e[d]) begin
            hold_e[d] = e + p_hold[d] * p_div[d];
            busy_e[d] = e + (p_hold[d] + p_gap[d]) * p_div[d];
            $display("edge %0d dut%0d pulse retriggered, hold until edge %0d", e, d, hold_e[d]);
        end else begin
            ent.dut    = d;
            ent.edge_n = e;
            drop_q.push_back(ent);
            $display("edge %0d dut%0d pulse ignored, drop expected", e, d);
        end
    endtask

    task automatic check_all();
        logic exp_lvl [2];
        logic exp_busy[2];
        logic exp_drop[2];
        for (int d = 0; d < 2; d++) begin
            exp_lvl[d]  = (edge_cnt >= acc_e[d]) && (edge_cnt < hold_e[d]);
            exp_busy[d] = (edge_cnt >= acc_e[d]) && (edge_cnt < busy_e[d]);
            exp_drop[d] = 1'b0;
        end
        for (int i = drop_q.size() - 1; i >= 0; i--) begin
            if (drop_q[i].edge_n == edge_cnt) begin
                exp_drop[drop_q[i].dut] = 1'b1;
                drop_q.delete(i);
            end
        end
        chk("level_out", 0, lvl_a,  exp_lvl[0]);
        chk("busy",      0, busy_a, exp_busy[0]);
        chk("drop",      0, drop_a, exp_drop[0]);
        chk("level_out", 1, lvl_b,  exp_lvl[1]);
        chk("busy",      1, busy_b, exp_busy[1]);
        chk("drop",      1, drop_b, exp_drop[1]);
    endtask

    task automatic step(input logic pa, input logic pb);
        pulse_a = pa;
        pulse_b = pb;
        @(posedge clk);
        edge_cnt++;
        if (pa) decide(0);
        if (pb) decide(1);
        #1;
        pulse_a = 1'b0;
        pulse_b = 1'b0;
        check_all();
    endtask

    task automatic go(input int rel, input logic pa, input logic pb);
        while (edge_cnt < base + rel - 1) step(1'b0, 1'b0);
        step(pa, pb);
    endtask

    initial begin
        int r;
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
        retrig = 1'b1;
`endif
        p_div  = '{4, 1};
        p_hold = '{3, 1};
        p_gap  = '{2, 0};
        model_reset();

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;

        // Basic hold
        base = edge_cnt;
        go(10, 1'b1, 1'b0);
        go(40, 1'b0, 1'b0);

        // Pulse during gap is dropped
        base = edge_cnt;
        go(10, 1'b1, 1'b0);
        go(25, 1'b1, 1'b0);
        go(40, 1'b0, 1'b0);

        // Pulse during hold
        base = edge_cnt;
        go(10, 1'b1, 1'b0);
        go(15, 1'b1, 1'b0);
        go(45, 1'b0, 1'b0);

        // Back-to-back: on gap expiry dropped, one edge later accepted
        base = edge_cnt;
        go(10, 1'b1, 1'b0);
        go(30, 1'b1, 1'b0);
        go(31, 1'b1, 1'b0);
        go(60, 1'b0, 1'b0);

        // Asynchronous reset mid-hold
        base = edge_cnt;
        go(10, 1'b1, 1'b0);
        go(14, 1'b0, 1'b0);
        #4;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
        r = edge_cnt - base;
        go(r + 1, 1'b1, 1'b0);
        go(r + 25, 1'b0, 1'b0);

        // Minimal parameters on the second instance
        base = edge_cnt;
        go(5,  1'b0, 1'b1);
        go(7,  1'b0, 1'b1);
        go(9,  1'b0, 1'b1);
        go(10, 1'b0, 1'b1);
        go(12, 1'b0, 1'b1);
        go(20, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_to_level.md
# pulse_to_level

Pulse-to-level converter: the opposite direction of the existing level-to-pulse path. It accepts single-cycle strobes, such as the lock FSM's on/off events, and drives a level output held for a programmable number of slow ticks, for example to hold a lock solenoid or an indicator LED. A minimum low gap follows each hold. The block has an internal prescaler, so it runs directly on the board clock and needs no external clock divider.

## Interface
- DIV, 100000000: clk cycles per slow tick; must be ≥1.
- HOLD_TICKS, 3: ticks `level_out` stays high; must be ≥1.
- GAP_TICKS, 1: ticks of forced low/busy time after each hold; must be ≥0.
- clk  input  1  board clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-low.
- pulse_in  input  1  request strobe, one cycle wide, already synchronous to clk.
- level_out  output  1  stretched level.
- busy  output  1  high in HOLD and GAP.
- drop  output  1  one-cycle strobe when a `pulse_in` is ignored.

## Operation
- States:
  - IDLE: `level_out`=0, `busy`=0.
  - HOLD: `level_out`=1, `busy`=1.
  - GAP: `level_out`=0, `busy`=1.
- Prescaler `presc` counts 0..DIV-1 and wraps. `tick` is asserted when `presc`==DIV-1. Each accepted pulse clears `presc` to 0, so hold length is exact.
- IDLE, `pulse_in`=1:
  - Next state HOLD.
  - `cnt` ← HOLD_TICKS-1.
  - `presc` ← 0.
- HOLD, on `tick`:
  - If `cnt`==0: go to GAP with `cnt` ← GAP_TICKS-1, or go directly to IDLE if GAP_TICKS==0.
  - Otherwise: `cnt` ← `cnt`-1.
- GAP, on `tick`:
  - If `cnt`==0: go to IDLE.
  - Otherwise: decrement `cnt`.
- `pulse_in` while in GAP: ignored, and `drop`=1 on the next cycle.
- `pulse_in` while in HOLD: behaviour depends on the configuration macro (see Configuration).
- Simultaneous pulse and expiry tick in HOLD: the macro rule applies; without the macro the pulse is dropped.
- Expiry tick in GAP simultaneous with a pulse: the pulse is dropped; the state still goes to IDLE.
- `cnt` width is $clog2(max(HOLD_TICKS,GAP_TICKS,2)). `presc` width is $clog2(max(DIV,2)). There is no overflow path.
- When DIV==1, `tick` is asserted every cycle.

## Timing
- All outputs are registered.
- Reset values: `level_out`=0, `busy`=0, `drop`=0, state IDLE, `presc`=0, `cnt`=0.
- Reset is asynchronous: asserting `rst` mid-HOLD or mid-GAP forces the outputs low immediately. The first acceptable pulse is sampled on the first posedge after `rst` deasserts.
- For a pulse accepted at edge N:
  - `level_out` is high after edge N through edge N+HOLD_TICKS·DIV, which is exactly HOLD_TICKS·DIV cycles.
  - `busy` falls after edge N+(HOLD_TICKS+GAP_TICKS)·DIV.
  - The earliest next accept is at edge N+(HOLD_TICKS+GAP_TICKS)·DIV+1.
- `drop` is high for exactly one cycle, following the edge at which the ignored pulse was sampled.
- Latency from pulse to `level_out` is 1 cycle.

## Configuration
- Macro: `PULSE_TO_LEVEL_RETRIGGER_EN`.
- Defined: a pulse in HOLD reloads `cnt` ← HOLD_TICKS-1 and `presc` ← 0, which extends the hold to HOLD_TICKS·DIV cycles after that edge. `drop` stays 0 in this case.
- Undefined: a pulse in HOLD is ignored and `drop` strobes.
- The GAP behaviour is identical in both builds.

## Structure
- Shared package `lock_pkg`:
  - State enum `p2l_state_t` (IDLE, HOLD, GAP).
  - Width helper constants.
  - Shared with the lock FSM's state typedefs.
- One sub-module, `tick_gen` (ports: clk, rst, clr, tick), holds the prescaler. It is the same counter style as the existing clock divider, but emits a clock-enable strobe rather than a derived clock.
- The FSM and hold/gap counter stay in `pulse_to_level`.

## Test plan
All scenarios use DIV=4, HOLD_TICKS=3, GAP_TICKS=2 unless stated.
- Basic: pulse at edge 10 → `level_out` high edges 10→22 (12 cycles), `busy` low after edge 30, `drop` never asserted.
- Gap drop: pulse at 10, second pulse at 25 → `level_out` unchanged, `drop`=1 for one cycle after edge 25.
- Hold re-pulse at edge 15, macro undefined → `level_out` still falls after edge 22, `drop` strobes. Macro defined → `level_out` falls after edge 27, `busy` falls after edge 35, no `drop`.
- Back-to-back: pulse at 10, then pulse at 31 → accepted, `level_out` high edges 31→43. Pulse at 30 instead → dropped.
- Reset mid-hold: `rst`=0 asynchronously at cycle 14.5 → all outputs 0 before edge 15; pulse one cycle after release → normal 12-cycle hold.
- Edge parameters: DIV=1, HOLD_TICKS=1, GAP_TICKS=0 → a pulse at edge 5 gives `level_out` high for exactly cycle 5→6, and a pulse at edge 7 is accepted.
